q_sys_ctrl_sequencer: RTL



---
 rtl/q_sys_seq_pkg.sv | 26 ++
 rtl/q_sys_seq_timer.sv | 23 ++
 rtl/q_sys_ctrl_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/q_sys_seq_pkg.sv
// Shared types and bit positions for the PIO control-byte sequencer.
package q_sys_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } seq_state_t;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_CLR      = 2;
  localparam int CTRL_MODE_LSB = 3;
  localparam int CTRL_REP_LSB  = 6;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_CORE_ERR = 2;
  localparam int ST_TIMEOUT  = 3;
  localparam int ST_ABORTED  = 4;
  localparam int ST_OVERRUN  = 5;
  localparam int ST_RUNS_LSB = 6;

endpackage

// File: rtl/q_sys_seq_timer.sv
// Per-run watchdog: clear has priority over enable; expired flags the last allowed cycle.
module q_sys_seq_timer #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + TO_W'(1);
  end

  assign expired = (cnt == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/q_sys_ctrl_sequencer.sv
// Turns the software control byte into req/ack/done handshakes with the matrix core,
// with repeat, abort and timeout, and reports a status byte plus an irq level.
module q_sys_ctrl_sequencer
  import q_sys_seq_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 65536,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ctrl_byte,
  output logic       core_req,
  output logic [2:0] core_mode,
  input  logic       core_ack,
  input  logic       core_done,
  input  logic       core_err,
  output logic [7:0] status,
  output logic       irq
);

  seq_state_t state, state_n;
  logic [5:1] flags, flags_n;
  logic [1:0] runs_left, runs_n;
  logic [2:0] mode_q, mode_n;
  // Only start and clear are edge-detected; reset high so held bits do not fire.
  logic       start_q, clr_q;
  logic       rise_start, rise_clr, abort;
  logic       busy, tmr_clr, tmr_exp;

  assign rise_start = ctrl_byte[CTRL_START] & ~start_q;
  assign rise_clr   = ctrl_byte[CTRL_CLR]   & ~clr_q;
  assign abort      = ctrl_byte[CTRL_ABORT];
  assign busy       = (state == S_ISSUE) || (state == S_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      flags     <= '0;
      runs_left <= '0;
      mode_q    <= '0;
      start_q   <= 1'b1;
      clr_q     <= 1'b1;
    end else begin
      state     <= state_n;
      flags     <= flags_n;
      runs_left <= runs_n;
      mode_q    <= mode_n;
      start_q   <= ctrl_byte[CTRL_START];
      clr_q     <= ctrl_byte[CTRL_CLR];
    end
  end

  always_comb begin
    state_n = state;
    flags_n = flags;
    runs_n  = runs_left;
    mode_n  = mode_q;
    tmr_clr = ~busy;

    if (rise_start && state != S_IDLE) flags_n[ST_OVERRUN] = 1'b1;

    case (state)
      S_IDLE: begin
        if (rise_start) begin
          mode_n  = ctrl_byte[CTRL_MODE_LSB +: 3];
          runs_n  = ctrl_byte[CTRL_REP_LSB +: 2];
          flags_n = '0;
          state_n = S_ISSUE;
        end else if (rise_clr) begin
          flags_n = '0;
        end
      end

      S_ISSUE, S_WAIT: begin
        // Priority: abort > completion > timeout > plain ack.
        if (abort) begin
          flags_n[ST_ABORTED] = 1'b1;
          state_n             = S_IDLE;
        end else if ((state == S_WAIT || core_ack) && core_done) begin
          if (core_err) begin
            // A failed run still completed, so done is reported alongside the error.
            flags_n[ST_CORE_ERR] = 1'b1;
            flags_n[ST_DONE]     = 1'b1;
            state_n              = S_ERROR;
          end else if (runs_left == 2'd0) begin
            flags_n[ST_DONE] = 1'b1;
            state_n          = S_DONE;
          end else begin
            runs_n  = runs_left - 2'd1;
            tmr_clr = 1'b1;
            state_n = S_ISSUE;
          end
        end else if (tmr_exp) begin
          flags_n[ST_TIMEOUT] = 1'b1;
          state_n             = S_ERROR;
        end else if (state == S_ISSUE && core_ack) begin
          state_n = S_WAIT;
        end
      end

      S_DONE, S_ERROR: begin
        if (rise_clr) begin
          flags_n = '0;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  q_sys_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (busy),
    .expired(tmr_exp)
  );

  assign core_req  = (state == S_ISSUE);
  assign core_mode = mode_q;
  assign status    = {runs_left, flags, busy};
  assign irq       = flags[ST_DONE] | flags[ST_CORE_ERR] | flags[ST_TIMEOUT];

endmodule
